// File: rtl/vga_pixel_fetch_if.sv
// Frame-buffer read port between the pixel fetcher and its RAM.
// The RAM returns ram_rdata one clock after it samples ram_addr.
interface vga_pixel_fetch_if;
  logic [16:0] ram_addr;
  logic [15:0] ram_rdata;

  modport master (output ram_addr, input ram_rdata);
  modport slave  (input ram_addr, output ram_rdata);
endinterface

// File: rtl/vga_pixel_fetch.sv
// Fetches a RD_H x RD_V window of RGB565 pixels from a frame buffer in step with
// an external timing generator and emits RGB888 video with a fixed 2-clock latency.
module vga_pixel_fetch #(
  parameter int RD_H   = 480,
  parameter int RD_V   = 272,
  parameter bit VS_POL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              de_in,
  input  logic              rd_in,
  input  logic [1:0]        mode,
  input  logic [23:0]       bg_color,
  vga_pixel_fetch_if.master ram,
  output logic              hs_out,
  output logic              vs_out,
  output logic              de_out,
  output logic [23:0]       rgb_out,
  output logic              frame_err
);

  localparam logic [16:0] ADDR_MAX  = 17'(RD_H * RD_V - 1);
  localparam logic [16:0] PIX_TOTAL = 17'(RD_H * RD_V);
  localparam logic [8:0]  X_MAX     = 9'(RD_H - 1);
  localparam logic [8:0]  Y_MAX     = 9'(RD_V - 1);
  localparam logic [8:0]  BAR_W     = 9'(RD_H / 8);

  typedef enum logic {WAIT_FRAME, RUN} state_t;

  state_t      stateQ, stateD;
  logic        vsQ;
  logic        frameStart;
  logic        run;
  logic        fetch;

  logic [16:0] addrQ, addrD;
  logic [8:0]  xQ, xD;
  logic [8:0]  yQ, yD;
  logic [16:0] cntQ, cntD;
  logic        errQ, errD;
  logic [1:0]  modeQ, modeD;

  logic        hs1Q, vs1Q, de1Q, rd1Q, live1Q;
  logic [8:0]  x1Q;
  logic [3:0]  yLo1Q;
  logic [1:0]  mode1Q;

  logic        hs2Q, vs2Q, de2Q;
  logic [23:0] rgbQ, rgbD;

  logic [4:0]  pixR;
  logic [5:0]  pixG;
  logic [4:0]  pixB;
  logic [8:0]  barIdx;

  assign frameStart = (vs_in == VS_POL) && (vsQ != VS_POL);
  assign run        = (stateQ == RUN);
  assign fetch      = run && rd_in && !frameStart;

  // A frame-start pixel reads address 0 even though the counter still holds last frame's value.
  assign ram.ram_addr = frameStart ? 17'd0 : addrQ;

  assign pixR = ram.ram_rdata[15:11];
  assign pixG = ram.ram_rdata[10:5];
  assign pixB = ram.ram_rdata[4:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateQ <= WAIT_FRAME;
    else     stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    if (stateQ == WAIT_FRAME && frameStart) stateD = RUN;
  end

  always_comb begin
    addrD = addrQ;
    xD    = xQ;
    yD    = yQ;
    cntD  = cntQ;
    errD  = errQ;
    modeD = modeQ;
    if (frameStart) begin
      addrD = '0;
      xD    = '0;
      yD    = '0;
      cntD  = '0;
      modeD = mode;
      if (run && cntQ != PIX_TOTAL) errD = 1'b1;
    end else if (fetch) begin
      if (addrQ != ADDR_MAX) addrD = addrQ + 17'd1;
      if (xQ == X_MAX) begin
        xD = '0;
        if (yQ != Y_MAX) yD = yQ + 9'd1;
      end else begin
        xD = xQ + 9'd1;
      end
      if (cntQ != '1) cntD = cntQ + 17'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsQ    <= 1'b0;
      addrQ  <= '0;
      xQ     <= '0;
      yQ     <= '0;
      cntQ   <= '0;
      errQ   <= 1'b0;
      modeQ  <= '0;
      hs1Q   <= 1'b0;
      vs1Q   <= 1'b0;
      de1Q   <= 1'b0;
      rd1Q   <= 1'b0;
      live1Q <= 1'b0;
      x1Q    <= '0;
      yLo1Q  <= '0;
      mode1Q <= '0;
      hs2Q   <= 1'b0;
      vs2Q   <= 1'b0;
      de2Q   <= 1'b0;
      rgbQ   <= '0;
    end else begin
      vsQ    <= vs_in;
      addrQ  <= addrD;
      xQ     <= xD;
      yQ     <= yD;
      cntQ   <= cntD;
      errQ   <= errD;
      modeQ  <= modeD;
      hs1Q   <= hs_in;
      vs1Q   <= vs_in;
      de1Q   <= de_in;
      rd1Q   <= rd_in && (run || frameStart);
      live1Q <= run || frameStart;
      x1Q    <= frameStart ? 9'd0 : xQ;
      yLo1Q  <= frameStart ? 4'd0 : yQ[3:0];
      mode1Q <= frameStart ? mode : modeQ;
      hs2Q   <= hs1Q;
      vs2Q   <= vs1Q;
      de2Q   <= de1Q;
      rgbQ   <= rgbD;
    end
  end

  // Stage-1 pixel colour; ram_rdata is valid here for the address issued one clock earlier.
  always_comb begin
    rgbD   = '0;
    barIdx = x1Q / BAR_W;
    if (de1Q && live1Q) begin
      if (!rd1Q) begin
        rgbD = bg_color;
      end else begin
        case (mode1Q)
          2'd0: rgbD = {pixR, pixR[4:2], pixG, pixG[5:4], pixB, pixB[4:2]};
          2'd1: begin
            case (barIdx)
              9'd0:    rgbD = 24'hFFFFFF;
              9'd1:    rgbD = 24'hFFFF00;
              9'd2:    rgbD = 24'h00FFFF;
              9'd3:    rgbD = 24'h00FF00;
              9'd4:    rgbD = 24'hFF00FF;
              9'd5:    rgbD = 24'hFF0000;
              9'd6:    rgbD = 24'h0000FF;
              default: rgbD = 24'h000000;
            endcase
          end
          2'd2:    rgbD = bg_color;
          default: rgbD = (x1Q[3:0] == 4'd0 || yLo1Q == 4'd0) ? 24'hFFFFFF : 24'h000000;
        endcase
      end
    end
  end

  assign hs_out    = hs2Q;
  assign vs_out    = vs2Q;
  assign de_out    = de2Q;
  assign rgb_out   = rgbQ;
  assign frame_err = errQ;

endmodule

// File: doc/vga_pixel_fetch.md
VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  RD_H  480  window width, pixels
  RD_V  272  window height, lines
  VS_POL  1  asserted level of vs_in
REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
  clk  in  1  pixel clock
  rst  in  1  reset, asynchronous, active-high
  hs_in  in  1  horizontal sync from timing generator
  vs_in  in  1  vertical sync from timing generator
  de_in  in  1  video valid from timing generator
  rd_in  in  1  window-pixel strobe from timing generator
  mode  in  2  0 RAM, 1 colour bars, 2 solid, 3 grid
  bg_color  in  24  RGB888 fill colour outside window and in mode 2
  ram_addr  out  17  frame-buffer read address
  ram_rdata  in  16  RGB565 data, 1-cycle synchronous read
  hs_out  out  1  hs_in delayed
  vs_out  out  1  vs_in delayed
  de_out  out  1  de_in delayed
  rgb_out  out  24  RGB888 pixel
  frame_err  out  1  sticky pixel-count mismatch flag
REQ-003 The block SHALL use rst as an asynchronous, active-high reset and clk as its only clock, with every flop on rising clk.

Function
REQ-010 frame_start SHALL be a one-cycle internal pulse when vs_in changes from ~VS_POL to VS_POL, detected via a registered copy of vs_in.
REQ-011 The block SHALL have a two-state FSM: WAIT_FRAME (after reset) and RUN; WAIT_FRAME -> RUN on frame_start; RUN stays in RUN.
REQ-012 In WAIT_FRAME, ram_addr SHALL hold 0, rd_in SHALL be ignored, and rgb_out SHALL be 0 whenever the delayed de is high.
REQ-013 On frame_start, ram_addr, window x (9 bit) and window y (9 bit) SHALL clear to 0 and the active mode SHALL be latched from mode; mode SHALL NOT change between frame starts.
REQ-014 In RUN, each cycle with rd_in=1 SHALL fetch the current ram_addr and then increment it.
REQ-015 ram_addr SHALL saturate at RD_H*RD_V-1 and SHALL NOT wrap within a frame.
REQ-016 x SHALL increment per rd_in cycle and wrap from RD_H-1 to 0; y SHALL increment on that wrap and saturate at RD_V-1.
REQ-017 frame_start SHALL take priority over a same-cycle rd_in: counters clear, and that cycle's pixel uses address 0 and is not counted.
REQ-018 hs_out, vs_out and de_out SHALL equal hs_in, vs_in and de_in delayed by exactly 2 clocks; rgb_out SHALL be aligned to the same 2-cycle latency.
REQ-019 rd_in, x and y SHALL be pipelined 2 stages alongside the sync signals.
REQ-020 For each pixel at stage 2, rgb_out SHALL be:
  - de=0: 0
  - de=1, window strobe 0: bg_color
  - mode 0: RGB565 expanded as {R5,R5[4:2]}, {G6,G6[5:4]}, {B5,B5[4:2]}
  - mode 1: 8 bars of RD_H/8 pixels, in order white, yellow, cyan, green, magenta, red, blue, black (full-scale 0xFF/0x00 components); x beyond the 8th bar is black
  - mode 2: bg_color
  - mode 3: 0xFFFFFF if x[3:0]==0 or y[3:0]==0, else 0x000000
REQ-021 A 17-bit per-frame pixel counter SHALL count rd_in cycles in RUN and saturate at 2^17-1.
REQ-022 At each frame_start while in RUN, frame_err SHALL be set if that count is not RD_H*RD_V; it is then cleared to 0.
REQ-023 frame_err SHALL be cleared only by rst; the first frame_start after reset SHALL NOT be checked.

Reset
REQ-030 While rst=1, all outputs and internal state SHALL be 0: ram_addr, rgb_out, hs_out, vs_out, de_out, frame_err, counters, pipeline, and the vs history register.
REQ-031 After rst releases, the FSM SHALL be in WAIT_FRAME.
REQ-032 Asserting rst mid-frame SHALL take effect immediately, without waiting for a clock.
REQ-033 After rst releases, no fetch SHALL occur until the next frame_start.

Verification
REQ-040 Reset, then drive 1280x720 timing with a 480x272 rd window and RAM data = address[15:0], mode 0. Required: ram_addr sweeps 0..130559 per frame, and pixel k has rgb_out = expansion of k 2 cycles later.
REQ-041 Mode 1, full frame. Required: window pixels x=0..59 give 0xFFFFFF, x=60..119 give 0xFFFF00, and x=420..479 give 0x000000; non-window de pixels give bg_color=0x123456.
REQ-042 Switch mode from 0 to 2 mid-frame. Required: output stays mode 0 until the next frame_start, then every window pixel is bg_color.
REQ-043 Drop 1 rd_in pulse in frame 2. Required: frame_err=1 from the frame-3 start onward, and it persists through later correct frames until rst.
REQ-044 Drive 140000 rd_in pulses in one frame. Required: ram_addr holds 130559, y holds 271, and frame_err sets at the next frame_start.
REQ-045 Assert rst for 3 cycles mid-line. Required: all outputs are 0 immediately, ram_addr stays 0 until a vs_in rising edge, and frame_err stays 0 after the first post-reset frame.
